io_bridge_fl: RTL and testbench

Peripheral-side IO bridge for the floating-point processor core; it is the other end of the core's IO port interface (`req_in`/`addr_in`/`io_in` and `out_en`/`addr_out`/`data_out`). Input side: one holding register per input address that peripherals write and the core reads with zero latency. Output side: a show-ahead FIFO that captures every core `out_en` write as an (address, data) pair and drains it to peripherals over a valid/ready handshake. The core cannot stall, so overflow drops the write and sets a sticky flag.

---
 rtl/io_bridge_fl.sv | 168 ++++++++++++++++
 tb/tb_io_bridge_fl.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/io_bridge_fl.sv
`default_nettype none
// ============================================================================
// Module      : io_bridge_fl
// Description : Peripheral-side IO bridge for the floating-point core.
//               Input side: one holding register per input address. Peripherals
//               write it, and the core reads it combinationally. A per-port
//               "fresh" flag marks values written since the last core read.
//               Output side: a show-ahead FIFO. It captures each core output
//               write as an {addr, data} pair and drains it over valid/ready.
//               The core cannot stall, so a push into a full FIFO (with no
//               simultaneous pop) is dropped and sets a sticky overflow flag.
// Config      : `define IO_BRIDGE_OVF_CNT_EN adds the ovf_cnt port, which holds
//               a saturating count of dropped pushes.
// Ports       : clk, rst (async, active-high)
//               req_in/addr_in/io_in         core input read port
//               out_en/addr_out/data_out     core output write port
//               pin_wr/pin_addr/pin_data     peripheral holding-register write
//               pin_fresh                    per-port written-since-read flags
//               pout_valid/pout_ready/pout_addr/pout_data/pout_level  FIFO drain
//               ovf/ovf_clr[/ovf_cnt]        overflow status
// Revision    : 1.0 - initial release
// ============================================================================
module io_bridge_fl #(
  parameter int NBMANT = 16,
  parameter int NBEXPO = 6,
  parameter int NUIOIN = 8,
  parameter int NUIOOU = 8,
  parameter int ODEPTH = 8,
  localparam int W  = NBMANT + NBEXPO + 1,
  localparam int AI = $clog2(NUIOIN),
  localparam int AO = $clog2(NUIOOU),
  localparam int LW = $clog2(ODEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_in,
  input  logic [AI-1:0]     addr_in,
  output logic [W-1:0]      io_in,
  input  logic              out_en,
  input  logic [AO-1:0]     addr_out,
  input  logic [W-1:0]      data_out,
  input  logic              pin_wr,
  input  logic [AI-1:0]     pin_addr,
  input  logic [W-1:0]      pin_data,
  output logic [NUIOIN-1:0] pin_fresh,
  output logic              pout_valid,
  input  logic              pout_ready,
  output logic [AO-1:0]     pout_addr,
  output logic [W-1:0]      pout_data,
  output logic [LW-1:0]     pout_level,
  output logic              ovf,
`ifdef IO_BRIDGE_OVF_CNT_EN
  output logic [15:0]       ovf_cnt,
`endif
  input  logic              ovf_clr
);

  localparam int        PW      = LW - 1;
  localparam int        EW      = AO + W;
  localparam logic [PW:0] C_DEPTH = ODEPTH[PW:0];

  // --------------------------------------------------------------------------
  // Input holding registers
  // --------------------------------------------------------------------------
  logic [W-1:0]      hold [NUIOIN];
  logic [NUIOIN-1:0] fresh;

  // An out-of-range pin_addr matches no register, so the write is ignored.
  // When a peripheral write and a core read hit the same port, the write
  // wins, so the fresh flag ends up set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUIOIN; i++) hold[i] <= '0;
      fresh <= '0;
    end else begin
      for (int i = 0; i < NUIOIN; i++) begin
        if (pin_wr && pin_addr == AI'(i)) begin
          hold[i]  <= pin_data;
          fresh[i] <= 1'b1;
        end else if (req_in && addr_in == AI'(i)) begin
          fresh[i] <= 1'b0;
        end
      end
    end
  end

  // The read mux returns 0 for addresses that have no holding register.
  always_comb begin
    io_in = '0;
    for (int i = 0; i < NUIOIN; i++) begin
      if (addr_in == AI'(i)) io_in = hold[i];
    end
  end

  assign pin_fresh = fresh;

  // --------------------------------------------------------------------------
  // Output FIFO
  // --------------------------------------------------------------------------
  logic [EW-1:0] mem [ODEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   level;
  logic          full;
  logic          pop;
  logic          push;
  logic          drop;

  assign full = (level == C_DEPTH);
  assign pop  = pout_valid && pout_ready;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  // In that case wr_ptr == rd_ptr, so the new entry lands in the slot that is
  // just being vacated, and it becomes the last entry once rd_ptr advances.
  assign push = out_en && (!full || pop);
  assign drop = out_en && full && !pop;

  // Valid is derived only from registered level, so there is no path from
  // ready to valid.
  assign pout_valid             = (level != '0);
  assign pout_level             = level;
  assign {pout_addr, pout_data} = mem[rd_ptr];

  // Memory is cleared on reset so the head reads 0 out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ODEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= {addr_out, data_out};
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Overflow status: set wins over clear
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          ovf <= 1'b0;
    else if (drop)    ovf <= 1'b1;
    else if (ovf_clr) ovf <= 1'b0;
  end

`ifdef IO_BRIDGE_OVF_CNT_EN
  // A drop in the same cycle as a clear restarts the count at 1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_cnt <= '0;
    end else if (drop) begin
      if (ovf_clr)                ovf_cnt <= 16'd1;
      else if (ovf_cnt != 16'hFFFF) ovf_cnt <= ovf_cnt + 16'd1;
    end else if (ovf_clr) begin
      ovf_cnt <= '0;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_io_bridge_fl.sv
`default_nettype none
// ============================================================================
// Module      : tb_io_bridge_fl
// Description : Self-checking bench for io_bridge_fl. Directed scenarios are
//               followed by a randomized phase. Every cycle is checked against
//               a queue/array reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_io_bridge_fl;
  localparam int W  = 23;
  localparam int AI = 3;
  localparam int AO = 3;
  localparam int D  = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_in;
  logic [AI-1:0] addr_in;
  logic [W-1:0]  io_in;
  logic          out_en;
  logic [AO-1:0] addr_out;
  logic [W-1:0]  data_out;
  logic          pin_wr;
  logic [AI-1:0] pin_addr;
  logic [W-1:0]  pin_data;
  logic [7:0]    pin_fresh;
  logic          pout_valid;
  logic          pout_ready;
  logic [AO-1:0] pout_addr;
  logic [W-1:0]  pout_data;
  logic [3:0]    pout_level;
  logic          ovf;
  logic          ovf_clr;
  logic [15:0]   ovf_cnt;

  always #5 clk = ~clk;

  io_bridge_fl dut (
    .clk(clk), .rst(rst),
    .req_in(req_in), .addr_in(addr_in), .io_in(io_in),
    .out_en(out_en), .addr_out(addr_out), .data_out(data_out),
    .pin_wr(pin_wr), .pin_addr(pin_addr), .pin_data(pin_data),
    .pin_fresh(pin_fresh),
    .pout_valid(pout_valid), .pout_ready(pout_ready),
    .pout_addr(pout_addr), .pout_data(pout_data), .pout_level(pout_level),
    .ovf(ovf),
`ifdef IO_BRIDGE_OVF_CNT_EN
    .ovf_cnt(ovf_cnt),
`endif
    .ovf_clr(ovf_clr)
  );

`ifndef IO_BRIDGE_OVF_CNT_EN
  assign ovf_cnt = '0;
`endif

  // Reference model
  logic [W-1:0]      m_hold [8];
  logic [7:0]        m_fresh;
  logic [AO+W-1:0]   m_q [$];
  logic              m_ovf;
  logic [15:0]       m_cnt;

  int vecs = 0;
  int errs = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_hold[i] = '0;
    m_fresh = '0;
    m_q.delete();
    m_ovf = 1'b0;
    m_cnt = '0;
  endtask

  task automatic idle();
    req_in = 0; addr_in = '0; out_en = 0; addr_out = '0; data_out = '0;
    pin_wr = 0; pin_addr = '0; pin_data = '0; pout_ready = 0; ovf_clr = 0;
  endtask

  task automatic check_outputs();
    logic [AO+W-1:0] head;
    chk("io_in", io_in, m_hold[addr_in]);
    chk("pin_fresh", pin_fresh, m_fresh);
    chk("pout_level", pout_level, m_q.size());
    chk("pout_valid", pout_valid, m_q.size() != 0);
    if (m_q.size() != 0) begin
      head = m_q[0];
      chk("pout_addr", pout_addr, head[AO+W-1:W]);
      chk("pout_data", pout_data, head[W-1:0]);
    end
    chk("ovf", ovf, m_ovf);
`ifdef IO_BRIDGE_OVF_CNT_EN
    chk("ovf_cnt", ovf_cnt, m_cnt);
`endif
  endtask

  // Checks the current outputs, advances the model by the driven inputs, then
  // steps one clock. It is entered and left 1ns after a rising edge.
  task automatic cycle();
    bit pop, drop;
    #1;
    check_outputs();
    pop  = (m_q.size() != 0) && pout_ready;
    drop = out_en && (m_q.size() == D) && !pop;
    if (pop) void'(m_q.pop_front());
    if (out_en && !drop) m_q.push_back({addr_out, data_out});
    if (req_in) m_fresh[addr_in] = 1'b0;
    if (pin_wr) begin
      m_hold[pin_addr]  = pin_data;
      m_fresh[pin_addr] = 1'b1;
    end
    if (drop) begin
      m_ovf = 1'b1;
      m_cnt = ovf_clr ? 16'd1 : (m_cnt == 16'hFFFF ? m_cnt : m_cnt + 16'd1);
    end else if (ovf_clr) begin
      m_ovf = 1'b0;
      m_cnt = '0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    idle();
    pout_ready = 1;
    for (int k = 0; k < 3 * D && m_q.size() != 0; k++) cycle();
    idle();
  endtask

  initial begin
    logic [W-1:0] exp_d;
    idle();
    rst = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    // Reset state
    check_outputs();
    chk("rst_pout_addr", pout_addr, 0);
    chk("rst_pout_data", pout_data, 0);
    chk("rst_io_in", io_in, 0);
    rst = 1'b0;

    // Write holding register 3, then read it back
    pin_wr = 1; pin_addr = 3; pin_data = 23'h12345;
    cycle(); idle();
    req_in = 1; addr_in = 3;
    #1;
    chk("rd3_io_in", io_in, 23'h12345);
    chk("rd3_fresh_before", pin_fresh[3], 1);
    cycle(); idle();
    chk("rd3_fresh_after", pin_fresh[3], 0);
    addr_in = 5;
    #1;
    chk("rd5_io_in", io_in, 0);
    cycle();

    // Same-cycle write and read of port 2
    idle();
    pin_wr = 1; pin_addr = 2; pin_data = 23'h0BBBB;
    cycle(); idle();
    pin_wr = 1; pin_addr = 2; pin_data = 23'h2AAAA; req_in = 1; addr_in = 2;
    #1;
    chk("wr_rd_old", io_in, 23'h0BBBB);
    cycle(); idle();
    addr_in = 2;
    #1;
    chk("wr_rd_new", io_in, 23'h2AAAA);
    chk("wr_rd_fresh", pin_fresh[2], 1);
    cycle();

    // Fill the FIFO, then overflow it once
    for (int i = 0; i < 8; i++) begin
      idle(); out_en = 1; addr_out = AO'(i); data_out = W'(i);
      cycle();
    end
    idle(); out_en = 1; addr_out = 3'd7; data_out = 23'h555;
    cycle(); idle();
    chk("full_level", pout_level, 8);
    chk("full_ovf", ovf, 1);
`ifdef IO_BRIDGE_OVF_CNT_EN
    chk("full_cnt", ovf_cnt, 1);
`endif
    ovf_clr = 1;
    cycle(); idle();
    chk("clr_ovf", ovf, 0);

    // Full FIFO with simultaneous push and pop
    out_en = 1; addr_out = 3'd5; data_out = 23'h99; pout_ready = 1;
    cycle(); idle();
    chk("fullpp_level", pout_level, 8);
    chk("fullpp_ovf", ovf, 0);
    for (int i = 0; i < 8; i++) begin
      exp_d = (i < 7) ? W'(i + 1) : 23'h99;
      pout_ready = 1;
      #1;
      chk("drain_order", pout_data, exp_d);
      cycle();
    end
    idle();
    chk("drained_valid", pout_valid, 0);

    // ovf_clr in the same cycle as an overflow: set wins
    for (int i = 0; i < 8; i++) begin
      idle(); out_en = 1; addr_out = AO'(i); data_out = W'(200 + i);
      cycle();
    end
    idle(); out_en = 1; data_out = 23'h777; ovf_clr = 1;
    cycle(); idle();
    chk("setwins_ovf", ovf, 1);
`ifdef IO_BRIDGE_OVF_CNT_EN
    chk("setwins_cnt", ovf_cnt, 1);
`endif
    ovf_clr = 1;
    cycle();
    drain();

    // Continuous pushes with toggling ready, across pointer wrap
    for (int i = 0; i < 20; i++) begin
      out_en = 1; addr_out = AO'(i); data_out = W'(1000 + i); pout_ready = (i % 2 == 0);
      cycle();
    end
    drain();

    // Async reset with five entries queued
    for (int i = 0; i < 5; i++) begin
      idle(); out_en = 1; addr_out = AO'(i); data_out = W'(300 + i);
      cycle();
    end
    idle();
    chk("pre_rst_level", pout_level, 5);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_valid", pout_valid, 0);
    chk("async_rst_level", pout_level, 0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_outputs();

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      pin_wr     = ($urandom_range(0, 3) == 0);
      pin_addr   = AI'($urandom);
      pin_data   = W'($urandom);
      req_in     = $urandom_range(0, 1);
      addr_in    = AI'($urandom);
      out_en     = ($urandom_range(0, 3) != 0);
      addr_out   = AO'($urandom);
      data_out   = W'($urandom);
      pout_ready = $urandom_range(0, 1);
      ovf_clr    = ($urandom_range(0, 15) == 0);
      cycle();
    end
    idle();
    #1;
    check_outputs();

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
`default_nettype wire
